// File: rtl/word_pack_pkg.sv
// Shared widths, channel field indices and FSM state encoding for word_pack.
// No logic. Defining WORD_PACK_PARITY_EN widens the word channel by one parity bit.
// Backpressure behaviour lives entirely in word_pack.
package word_pack_pkg;

  localparam int BYTE_W        = 8;
  localparam int WORD_W        = 16;

  // Byte channel (__in0) layout
  localparam int IN_W          = 10;
  localparam int IN_VALID_BIT  = 9;
  localparam int IN_ORDER_BIT  = 8;
  localparam int IN_DATA_LSB   = 0;

  // Word channel (__out0) layout
  localparam int OUT_VALID_BIT = 16;
  localparam int OUT_WORD_LSB  = 0;
`ifdef WORD_PACK_PARITY_EN
  localparam int OUT_PARITY_BIT = 17;
  localparam int OUT_W          = 18;
`else
  localparam int OUT_W          = 17;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/word_pack_asm.sv
// Purely combinational join of two bytes into a 16-bit word under a byte-order flag.
// Latency: zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module word_pack_asm
  import word_pack_pkg::*;
(
  input  logic [BYTE_W-1:0] first,
  input  logic [BYTE_W-1:0] second,
  input  logic              order,
  output logic [WORD_W-1:0] word
);

  // order=0 puts the earlier byte in the high half (big-endian), order=1 swaps it
  assign word = order ? {second, first} : {first, second};

endmodule

// File: rtl/word_pack.sv
// Pairs a byte stream into 16-bit words (per-word byte order) on a valid/ready word channel.
// Latency: word is registered on the edge that accepts its second byte, visible the next cycle.
// Backpressure: in_ready = (state != FULL) | out_ready; optional parity via WORD_PACK_PARITY_EN.
module word_pack
  import word_pack_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  __in0,
  input  logic             __in1,
  output logic [OUT_W-1:0] __out0,
  output logic             __out1
);

  logic              in_valid;
  logic              order_in;
  logic [BYTE_W-1:0] data_in;
  logic              out_ready;
  logic              in_ready;
  logic              byte_xfer;

  state_t            state;
  state_t            next_state;
  logic              load_first;
  logic              load_word;

  logic [BYTE_W-1:0] first_q;
  logic              order_q;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] asm_word;

  assign in_valid  = __in0[IN_VALID_BIT];
  assign order_in  = __in0[IN_ORDER_BIT];
  assign data_in   = __in0[IN_DATA_LSB +: BYTE_W];
  assign out_ready = __in1;

  // While FULL a new byte may only enter in the same edge the held word drains
  assign in_ready  = (state != FULL) | out_ready;
  assign byte_xfer = in_valid & in_ready;

  // Next-state and capture enables for the EMPTY/HALF/FULL handshake
  always_comb begin
    next_state = state;
    load_first = 1'b0;
    load_word  = 1'b0;
    case (state)
      EMPTY: begin
        if (byte_xfer) begin
          next_state = HALF;
          load_first = 1'b1;
        end
      end
      HALF: begin
        if (byte_xfer) begin
          next_state = FULL;
          load_word  = 1'b1;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (byte_xfer) begin
            next_state = HALF;
            load_first = 1'b1;
          end else begin
            next_state = EMPTY;
          end
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // State register; reset drops any held byte or pending word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= next_state;
  end

  word_pack_asm u_asm (
    .first  (first_q),
    .second (data_in),
    .order  (order_q),
    .word   (asm_word)
  );

  // First byte and its order flag; the order bit sent with the second byte is never latched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q <= '0;
      order_q <= 1'b0;
    end else if (load_first) begin
      first_q <= data_in;
      order_q <= order_in;
    end
  end

  // Output word, held stable for as long as the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           word_q <= '0;
    else if (load_word) word_q <= asm_word;
  end

  assign __out0[OUT_VALID_BIT]               = (state == FULL);
  assign __out0[OUT_WORD_LSB +: WORD_W]      = word_q;

`ifdef WORD_PACK_PARITY_EN
  logic parity_q;

  // Even parity captured alongside the word so the two always match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           parity_q <= 1'b0;
    else if (load_word) parity_q <= ^asm_word;
  end

  assign __out0[OUT_PARITY_BIT] = parity_q;
`endif

  assign __out1 = in_ready;

endmodule

// File: tb/tb_word_pack.sv
// Self-checking bench for word_pack: vector table, backpressure, streaming and reset corners.
// Expected words are queued when the second byte is driven and popped on each word transfer.
// Parity checks are active when WORD_PACK_PARITY_EN is defined.
module tb_word_pack;

`ifdef WORD_PACK_PARITY_EN
  localparam int OW = 18;
`else
  localparam int OW = 17;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          order;
  logic [7:0]    data;
  logic          out_ready;
  logic [OW-1:0] out0;
  logic          in_ready;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  b0;
    logic        o0;
    logic [7:0]  b1;
    logic        o1;
    logic [15:0] w;
    logic        p;
  } vec_t;

  vec_t vecs[9];

  // {parity, word}
  logic [16:0] sb[$];

  word_pack dut (
    .clk    (clk),
    .rst    (rst),
    .__in0  ({in_valid, order, data}),
    .__in1  (out_ready),
    .__out0 (out0),
    .__out1 (in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic o, input logic [7:0] d);
    in_valid = v;
    order    = o;
    data     = d;
  endtask

  task automatic push(input logic [15:0] w);
    sb.push_back({^w, w});
  endtask

  // Word transfers are decided at the next rising edge; inputs are stable at the falling edge
  always @(negedge clk) begin
    if (rst && out0[16] && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", {16'h0, out0[15:0]}, 32'hFFFF_FFFF);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("sb_word", {16'h0, out0[15:0]}, {16'h0, e[15:0]});
`ifdef WORD_PACK_PARITY_EN
        chk("sb_parity", {31'h0, out0[17]}, {31'h0, e[16]});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{8'hAB, 1'b0, 8'hCD, 1'b0, 16'hABCD, 1'b0};
    vecs[1] = '{8'hAB, 1'b1, 8'hCD, 1'b1, 16'hCDAB, 1'b0};
    vecs[2] = '{8'hAB, 1'b1, 8'hCD, 1'b0, 16'hCDAB, 1'b0};
    vecs[3] = '{8'hAB, 1'b0, 8'hCD, 1'b1, 16'hABCD, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 8'h01, 1'b0, 16'h0001, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 8'h03, 1'b0, 16'h0003, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 8'h00, 1'b0, 16'h0001, 1'b1};
    vecs[7] = '{8'hFF, 1'b1, 8'h00, 1'b0, 16'h00FF, 1'b0};
    vecs[8] = '{8'h80, 1'b0, 8'h7F, 1'b1, 16'h807F, 1'b0};

    rst       = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'h0, out0[16]}, 32'h0);
    chk("reset_word", {16'h0, out0[15:0]}, 32'h0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
`ifdef WORD_PACK_PARITY_EN
    chk("reset_parity", {31'h0, out0[17]}, 32'h0);
`endif
    rst = 1'b1;
    tick();

    // Table: two bytes, one word, out_valid for exactly one cycle
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].o0, vecs[i].b0);
      tick();
      chk("vec_half_valid", {31'h0, out0[16]}, 32'h0);
      chk("vec_half_in_ready", {31'h0, in_ready}, 32'h1);
      drive(1'b1, vecs[i].o1, vecs[i].b1);
      push(vecs[i].w);
      tick();
      chk("vec_full_valid", {31'h0, out0[16]}, 32'h1);
      chk("vec_word", {16'h0, out0[15:0]}, {16'h0, vecs[i].w});
      chk("vec_full_in_ready", {31'h0, in_ready}, 32'h1);
`ifdef WORD_PACK_PARITY_EN
      chk("vec_parity", {31'h0, out0[17]}, {31'h0, vecs[i].p});
`endif
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("vec_one_cycle_valid", {31'h0, out0[16]}, 32'h0);
    end

    // Backpressure: hold the word five cycles, then drain with a simultaneous new byte
    drive(1'b1, 1'b0, 8'h9A);
    tick();
    drive(1'b1, 1'b0, 8'hBC);
    push(16'h9ABC);
    out_ready = 1'b0;
    tick();
    drive(1'b1, 1'b0, 8'h12);
    repeat (5) begin
      chk("hold_valid", {31'h0, out0[16]}, 32'h1);
      chk("hold_word", {16'h0, out0[15:0]}, 32'h9ABC);
      chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    chk("drain_half_valid", {31'h0, out0[16]}, 32'h0);
    drive(1'b1, 1'b1, 8'h34);
    push(16'h1234);
    tick();
    chk("drain_next_valid", {31'h0, out0[16]}, 32'h1);
    chk("drain_next_word", {16'h0, out0[15:0]}, 32'h1234);
    drive(1'b0, 1'b0, 8'h00);
    tick();

    // Back-to-back bytes: one word every two cycles, no bubbles
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      logic [7:0] pb;
      b  = 8'(i);
      pb = 8'(i - 1);
      drive(1'b1, 1'b0, b);
      if (i % 2 == 1) push({pb, b});
      tick();
      chk("stream_in_ready", {31'h0, in_ready}, 32'h1);
      chk("stream_valid", {31'h0, out0[16]}, {31'h0, (i % 2 == 1)});
    end
    drive(1'b0, 1'b0, 8'h00);
    tick();

    // Reset with a half word held: the 55 byte must vanish
    drive(1'b1, 1'b0, 8'h55);
    tick();
    drive(1'b1, 1'b0, 8'h99);
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, out0[16]}, 32'h0);
    chk("midrst_word", {16'h0, out0[15:0]}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    tick();
    chk("midrst_hold_valid", {31'h0, out0[16]}, 32'h0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h66);
    tick();
    chk("after_rst_half_valid", {31'h0, out0[16]}, 32'h0);
    drive(1'b1, 1'b0, 8'h77);
    push(16'h6677);
    tick();
    chk("after_rst_valid", {31'h0, out0[16]}, 32'h1);
    chk("after_rst_word", {16'h0, out0[15:0]}, 32'h6677);
    drive(1'b0, 1'b0, 8'h00);
    tick();

    // Every queued word must have come out
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    chk("sb_drained", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
